// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank, with power-gate sequencing.
// Define MEM_BANK_ARB_FIXED_PRIO_EN for fixed priority (lowest port index wins).
module mem_bank_arbiter #(
  parameter int NumPorts  = 2,
  parameter int NumWords  = 1024,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*32-1:0]        wdata_i,
  input  logic [NumPorts*4-1:0]         be_i,
  output logic [NumPorts-1:0]           gnt_o,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [31:0]                   rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic [31:0]                   mem_rdata_i,
  input  logic                          sleep_req_i,
  output logic                          sleep_ack_o,
  output logic                          mem_pwrgate_no,
  input  logic                          mem_pwrgate_ack_ni
);

  typedef enum logic [2:0] {
    ACTIVE,
    DRAIN,
    GATING,
    OFF,
    WAKING
  } state_e;

  localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  state_e              state_q, state_d;
  logic [NumPorts-1:0] gnt;
  logic [NumPorts-1:0] rvalid_q, rvalid_d;
  logic [PtrW-1:0]     win;
  logic                grant_en;
  logic                any_gnt;

  // A rising sleep request blocks the grant in the same cycle.
  assign grant_en = rst_ni && (state_q == ACTIVE) && !sleep_req_i;

`ifdef MEM_BANK_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (req_i[i]) win = PtrW'(i);
    end
  end
`else
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NumPorts-1:0] hi_req;

  // Lowest requester at/above the pointer, else lowest overall (wrap).
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NumPorts; i++) begin
      hi_req[i] = req_i[i] && (PtrW'(i) >= ptr_q);
    end
    win = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (hi_req[i] || (hi_req == '0 && req_i[i])) win = PtrW'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = (win == PtrW'(NumPorts - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (grant_en && (|req_i)) gnt[win] = 1'b1;
  end

  assign any_gnt = |gnt;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (gnt[i]) begin
        mem_we_o    = we_i[i];
        mem_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
        mem_wdata_o = wdata_i[i*32 +: 32];
        mem_be_o    = be_i[i*4 +: 4];
      end
    end
  end

  assign rvalid_d = gnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE: begin
        if (sleep_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!sleep_req_i) begin
          state_d = ACTIVE;
        end else if (rvalid_q == '0) begin
          state_d = GATING;
        end
      end
      GATING: begin
        if (!mem_pwrgate_ack_ni) state_d = OFF;
      end
      OFF: begin
        if (!sleep_req_i) state_d = WAKING;
      end
      WAKING: begin
        if (mem_pwrgate_ack_ni) state_d = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ACTIVE;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o          = gnt;
  assign mem_req_o      = any_gnt;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = mem_rdata_i;
  assign sleep_ack_o    = (state_q == OFF);
  assign mem_pwrgate_no = !((state_q == GATING) || (state_q == OFF));

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_gnt_active: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (|gnt_o) |-> (state_q == ACTIVE));
  a_req_ungated: assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem_req_o |-> mem_pwrgate_ack_ni);
`endif

endmodule

// File: doc/mem_bank_arbiter.md
Name: mem_bank_arbiter

Overview:
- Shares one single-port SRAM bank between NumPorts requesters using round-robin arbitration with one-cycle read latency.
- Routes each read response back to the port that issued it.
- Sequences the bank's power-gate handshake: drain outstanding traffic, gate the bank, then un-gate on wake.
- Sits between the bus demux and the memory bank wrapper, one instance per bank.

Parameters:
NumPorts, 2, number of requesters (2..8)
NumWords, 1024, words in the bank
AddrWidth, $clog2(NumWords), word address width (dependent, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumPorts  per-port request
we_i  in  NumPorts  per-port write enable
addr_i  in  NumPorts x AddrWidth  per-port word address
wdata_i  in  NumPorts x 32  per-port write data
be_i  in  NumPorts x 4  per-port byte enables
gnt_o  out  NumPorts  per-port grant (one-hot or zero)
rvalid_o  out  NumPorts  per-port response valid
rdata_o  out  32  read data, shared, qualified by rvalid_o
mem_req_o  out  1  bank request
mem_we_o  out  1  bank write enable
mem_addr_o  out  AddrWidth  bank address
mem_wdata_o  out  32  bank write data
mem_be_o  out  4  bank byte enables
mem_rdata_i  in  32  bank read data, valid 1 cycle after mem_req_o
sleep_req_i  in  1  power manager requests bank off (level)
sleep_ack_o  out  1  bank is gated
mem_pwrgate_no  out  1  to bank, active-low gate
mem_pwrgate_ack_ni  in  1  from bank, active-low gate acknowledge

Behaviour:
- Reset values:
  - gnt_o=0, rvalid_o=0, mem_req_o=0, sleep_ack_o=0, mem_pwrgate_no=1.
  - Priority pointer = 0; FSM = ACTIVE.
  - rdata_o passes mem_rdata_i through unregistered.
- FSM states: ACTIVE, DRAIN, GATING, OFF, WAKING.
- ACTIVE, arbitration:
  - Grant is combinational, same cycle as req.
  - Winner is the first requesting port at or after the pointer, scanning upward and wrapping from NumPorts-1 to 0.
  - Granted port drives mem_* the same cycle; mem_req_o = |gnt_o.
  - On a grant, pointer <= winner+1 mod NumPorts. With no grant, pointer is held.
  - Requesters hold req/addr/etc. until granted.
- Response:
  - rvalid_o[winner] asserts exactly 1 cycle after each grant, for reads and writes alike.
  - rdata_o is meaningful only for reads.
  - Back-to-back grants give back-to-back rvalid, one per cycle.
- ACTIVE -> DRAIN when sleep_req_i=1. No grants are issued from that cycle onward.
- DRAIN:
  - -> GATING once no response is pending, i.e. the cycle after the last grant has passed.
  - -> ACTIVE instead if sleep_req_i drops first.
- GATING:
  - mem_pwrgate_no=0.
  - Waits for mem_pwrgate_ack_ni=0, then -> OFF.
  - sleep_req_i deassertion is ignored until OFF is reached.
- OFF:
  - sleep_ack_o=1, mem_pwrgate_no=0.
  - -> WAKING when sleep_req_i=0; sleep_ack_o drops in the same transition.
- WAKING:
  - mem_pwrgate_no=1.
  - Waits for mem_pwrgate_ack_ni=1, then -> ACTIVE; grants resume the following cycle.
- In all non-ACTIVE states gnt_o=0 and mem_req_o=0. Pending requests stay pending and are not dropped.
- Simultaneous sleep_req_i rise and req: no grant is issued in that cycle. The transition is evaluated first.
- Reset mid-operation returns immediately to reset values. Any pending rvalid is discarded and the bank is un-gated.
- Assertions (sim only):
  - gnt_o is one-hot0.
  - No grant outside ACTIVE.
  - No request to a gated bank.

Optional Feature:
MEM_BANK_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest port index wins; the pointer register is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Ports 0 and 1 request reads continuously from addr 0x010 and 0x020 -> grants alternate 0,1,0,1. Each rvalid arrives 1 cycle later on the correct port with the preloaded data.
- Port 1 writes 0xDEADBEEF, be=4'b0011, at 0x005; port 0 then reads 0x005 -> rdata 0x????BEEF, upper bytes keep prior contents.
- Read granted on port 0 in the same cycle sleep_req_i rises -> no grant that cycle. The earlier grant's rvalid still arrives; then GATING, mem_pwrgate_no=0; with ack low after 3 cycles, sleep_ack_o=1.
- In OFF, port 1 holds req; sleep_req_i drops; ack returns after 2 cycles -> WAKING then ACTIVE, and port 1 is granted the cycle after ACTIVE is entered.
- rst_ni pulsed low during GATING with a request pending -> mem_pwrgate_no=1, gnt_o=0, sleep_ack_o=0 immediately. After release, the request is granted on port 0 first (pointer=0).
- Macro defined, both ports requesting continuously -> port 0 granted every cycle, port 1 never granted.
